// File: rtl/mips_pipe_pkg.sv
// -----------------------------------------------------------------------------
// mips_pipe_pkg
// Shared definitions for the ID/EX pipeline stage and its forwarding logic:
//   DEF_DATA_W / DEF_REG_W : default datapath and register-index widths
//   BUBBLE_CNT_W           : width of the bubble statistics counter
//   fwd_sel_e              : operand forwarding source select
//   sat_inc_bubble()       : saturating increment for the bubble counter
// -----------------------------------------------------------------------------
package mips_pipe_pkg;

    localparam int DEF_DATA_W   = 16;
    localparam int DEF_REG_W    = 5;
    localparam int BUBBLE_CNT_W = 16;

    typedef enum logic [1:0] {
        FWD_NONE = 2'd0,
        FWD_MEM  = 2'd1,
        FWD_WB   = 2'd2
    } fwd_sel_e;

    // Counter sticks at all-ones instead of wrapping back to zero.
    function automatic logic [BUBBLE_CNT_W-1:0] sat_inc_bubble(
        input logic [BUBBLE_CNT_W-1:0] cnt
    );
        logic [BUBBLE_CNT_W-1:0] res;
        if (cnt == {BUBBLE_CNT_W{1'b1}}) begin
            res = cnt;
        end else begin
            res = cnt + {{(BUBBLE_CNT_W-1){1'b0}}, 1'b1};
        end
        return res;
    endfunction

endpackage

// File: rtl/fwd_sel.sv
// -----------------------------------------------------------------------------
// fwd_sel
// Picks the forwarding source for one EX operand register index.
//   src           : register index the operand was read from
//   mem_reg_write : EX/MEM stage will write a register
//   mem_rd        : EX/MEM destination index
//   wb_reg_write  : MEM/WB stage will write a register
//   wb_rd         : MEM/WB destination index
//   sel           : FWD_MEM, FWD_WB or FWD_NONE
// The younger EX/MEM result wins over MEM/WB. Index 0 is hard-wired zero and is
// never forwarded.
// -----------------------------------------------------------------------------
module fwd_sel
    import mips_pipe_pkg::*;
#(
    parameter int REG_W = DEF_REG_W
) (
    input  logic [REG_W-1:0] src,
    input  logic             mem_reg_write,
    input  logic [REG_W-1:0] mem_rd,
    input  logic             wb_reg_write,
    input  logic [REG_W-1:0] wb_rd,
    output fwd_sel_e         sel
);

    logic mem_hit_s;
    logic wb_hit_s;

    assign mem_hit_s = mem_reg_write && (mem_rd != {REG_W{1'b0}}) && (mem_rd == src);
    assign wb_hit_s  = wb_reg_write  && (wb_rd  != {REG_W{1'b0}}) && (wb_rd  == src);

    // Priority select: EX/MEM result, then MEM/WB result, then register file value.
    always_comb begin
        sel = FWD_NONE;
        if (mem_hit_s) begin
            sel = FWD_MEM;
        end else if (wb_hit_s) begin
            sel = FWD_WB;
        end else begin
            sel = FWD_NONE;
        end
    end

endmodule

// File: rtl/id_ex_fwd_stage.sv
// -----------------------------------------------------------------------------
// id_ex_fwd_stage
// ID/EX pipeline register with operand forwarding and load-use hazard detection.
// Ports:
//   clk, rst                       : clock, synchronous active-high reset
//   id_*                           : decoded instruction from ID
//   stall                          : hold the register contents
//   flush                          : replace the register contents with a bubble
//   mem_reg_write/mem_rd/mem_result: EX/MEM writeback info (forward source)
//   wb_reg_write/wb_rd/wb_result   : MEM/WB writeback info (forward source)
//   ex_*                           : instruction presented to EX; ex_op_a and
//                                    ex_rt_fwd are already forwarded
//   hazard_stall                   : load-use stall request to IF/ID
//   bubble_cnt                     : saturating count of inserted bubbles
// Update priority each edge: rst > flush > hazard_stall > stall > load.
// -----------------------------------------------------------------------------
module id_ex_fwd_stage
    import mips_pipe_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int REG_W  = DEF_REG_W
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    id_valid,
    input  logic [DATA_W-1:0]       id_rs_val,
    input  logic [DATA_W-1:0]       id_rt_val,
    input  logic [DATA_W-1:0]       id_imm,
    input  logic [REG_W-1:0]        id_rs,
    input  logic [REG_W-1:0]        id_rt,
    input  logic [REG_W-1:0]        id_rd,
    input  logic                    id_alu_src,
    input  logic                    id_reg_write,
    input  logic                    id_mem_read,
    input  logic                    stall,
    input  logic                    flush,
    input  logic                    mem_reg_write,
    input  logic [REG_W-1:0]        mem_rd,
    input  logic [DATA_W-1:0]       mem_result,
    input  logic                    wb_reg_write,
    input  logic [REG_W-1:0]        wb_rd,
    input  logic [DATA_W-1:0]       wb_result,
    output logic                    ex_valid,
    output logic [DATA_W-1:0]       ex_op_a,
    output logic [DATA_W-1:0]       ex_rt_fwd,
    output logic [DATA_W-1:0]       ex_imm,
    output logic [REG_W-1:0]        ex_rd,
    output logic                    ex_alu_src,
    output logic                    ex_reg_write,
    output logic                    ex_mem_read,
    output logic                    hazard_stall,
    output logic [BUBBLE_CNT_W-1:0] bubble_cnt
);

    logic                    valid_q,     valid_d;
    logic [DATA_W-1:0]       rs_val_q,    rs_val_d;
    logic [DATA_W-1:0]       rt_val_q,    rt_val_d;
    logic [DATA_W-1:0]       imm_q,       imm_d;
    logic [REG_W-1:0]        rs_q,        rs_d;
    logic [REG_W-1:0]        rt_q,        rt_d;
    logic [REG_W-1:0]        rd_q,        rd_d;
    logic                    alu_src_q,   alu_src_d;
    logic                    reg_write_q, reg_write_d;
    logic                    mem_read_q,  mem_read_d;
    logic [BUBBLE_CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;

    logic     hazard_s;
    fwd_sel_e rs_sel_s;
    fwd_sel_e rt_sel_s;

    // Load-use: the load in EX cannot supply its data in time for the
    // instruction currently in ID, so ID must wait one cycle.
    assign hazard_s = valid_q && mem_read_q && (rd_q != {REG_W{1'b0}}) && id_valid &&
                      ((rd_q == id_rs) || (rd_q == id_rt));

    // Next-state for the ID/EX register and bubble counter.
    always_comb begin
        valid_d      = valid_q;
        rs_val_d     = rs_val_q;
        rt_val_d     = rt_val_q;
        imm_d        = imm_q;
        rs_d         = rs_q;
        rt_d         = rt_q;
        rd_d         = rd_q;
        alu_src_d    = alu_src_q;
        reg_write_d  = reg_write_q;
        mem_read_d   = mem_read_q;
        bubble_cnt_d = bubble_cnt_q;
        if (flush || hazard_s) begin
            // Bubble: kill controls only, data fields keep their old values.
            valid_d      = 1'b0;
            alu_src_d    = 1'b0;
            reg_write_d  = 1'b0;
            mem_read_d   = 1'b0;
            bubble_cnt_d = sat_inc_bubble(bubble_cnt_q);
        end else if (stall) begin
            valid_d      = valid_q;
        end else begin
            valid_d      = id_valid;
            rs_val_d     = id_rs_val;
            rt_val_d     = id_rt_val;
            imm_d        = id_imm;
            rs_d         = id_rs;
            rt_d         = id_rt;
            rd_d         = id_rd;
            alu_src_d    = id_alu_src;
            reg_write_d  = id_reg_write;
            mem_read_d   = id_mem_read;
        end
    end

    // ID/EX state register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q      <= 1'b0;
            rs_val_q     <= {DATA_W{1'b0}};
            rt_val_q     <= {DATA_W{1'b0}};
            imm_q        <= {DATA_W{1'b0}};
            rs_q         <= {REG_W{1'b0}};
            rt_q         <= {REG_W{1'b0}};
            rd_q         <= {REG_W{1'b0}};
            alu_src_q    <= 1'b0;
            reg_write_q  <= 1'b0;
            mem_read_q   <= 1'b0;
            bubble_cnt_q <= {BUBBLE_CNT_W{1'b0}};
        end else begin
            valid_q      <= valid_d;
            rs_val_q     <= rs_val_d;
            rt_val_q     <= rt_val_d;
            imm_q        <= imm_d;
            rs_q         <= rs_d;
            rt_q         <= rt_d;
            rd_q         <= rd_d;
            alu_src_q    <= alu_src_d;
            reg_write_q  <= reg_write_d;
            mem_read_q   <= mem_read_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    fwd_sel #(.REG_W(REG_W)) u_fwd_rs (
        .src           (rs_q),
        .mem_reg_write (mem_reg_write),
        .mem_rd        (mem_rd),
        .wb_reg_write  (wb_reg_write),
        .wb_rd         (wb_rd),
        .sel           (rs_sel_s)
    );

    fwd_sel #(.REG_W(REG_W)) u_fwd_rt (
        .src           (rt_q),
        .mem_reg_write (mem_reg_write),
        .mem_rd        (mem_rd),
        .wb_reg_write  (wb_reg_write),
        .wb_rd         (wb_rd),
        .sel           (rt_sel_s)
    );

    // Operand A mux; evaluated every cycle so a held instruction still
    // picks up results that arrive while it waits.
    always_comb begin
        ex_op_a = rs_val_q;
        case (rs_sel_s)
            FWD_MEM:  ex_op_a = mem_result;
            FWD_WB:   ex_op_a = wb_result;
            FWD_NONE: ex_op_a = rs_val_q;
            default:  ex_op_a = rs_val_q;
        endcase
    end

    // rt operand mux (store data / second ALU operand before the imm mux).
    always_comb begin
        ex_rt_fwd = rt_val_q;
        case (rt_sel_s)
            FWD_MEM:  ex_rt_fwd = mem_result;
            FWD_WB:   ex_rt_fwd = wb_result;
            FWD_NONE: ex_rt_fwd = rt_val_q;
            default:  ex_rt_fwd = rt_val_q;
        endcase
    end

    assign ex_valid     = valid_q;
    assign ex_imm       = imm_q;
    assign ex_rd        = rd_q;
    assign ex_alu_src   = alu_src_q;
    assign ex_reg_write = reg_write_q && valid_q;
    assign ex_mem_read  = mem_read_q && valid_q;
    assign hazard_stall = hazard_s;
    assign bubble_cnt   = bubble_cnt_q;

endmodule

// File: doc/id_ex_fwd_stage.md
ID_EX_FWD_STAGE -- requirements
Module: id_ex_fwd_stage

Interface
REQ-001 SHALL have parameter DATA_W, default 16, datapath width.
REQ-002 SHALL have parameter REG_W, default 5, register-index width.
REQ-003 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have ports id_valid 1, id_rs_val DATA_W, id_rt_val DATA_W, id_imm DATA_W, id_rs REG_W, id_rt REG_W, id_rd REG_W, id_alu_src 1, id_reg_write 1, id_mem_read 1; all inputs; decoded instruction from ID.
REQ-006 SHALL have ports stall input 1 (hold register) and flush input 1 (kill register contents).
REQ-007 SHALL have ports mem_reg_write 1, mem_rd REG_W, mem_result DATA_W; all inputs; EX/MEM writeback info.
REQ-008 SHALL have ports wb_reg_write 1, wb_rd REG_W, wb_result DATA_W; all inputs; MEM/WB writeback info.
REQ-009 SHALL have outputs ex_valid 1, ex_op_a DATA_W, ex_rt_fwd DATA_W, ex_imm DATA_W, ex_rd REG_W, ex_alu_src 1, ex_reg_write 1, ex_mem_read 1; ex_rt_fwd/ex_imm feed the downstream 2:1 operand mux selected by ex_alu_src.
REQ-010 SHALL have outputs hazard_stall 1 (load-use request to IF/ID) and bubble_cnt 16.

Function
REQ-011 SHALL update the ID/EX register each clk edge with priority: rst > flush > hazard_stall > stall > load.
REQ-012 On flush or hazard_stall SHALL load a bubble: valid, reg_write, mem_read, alu_src cleared; data fields hold prior values.
REQ-013 On stall (no flush/hazard) SHALL hold all register fields unchanged.
REQ-014 On load SHALL capture all id_* fields; latency ID to EX outputs one cycle.
REQ-015 ex_reg_write and ex_mem_read SHALL be registered values ANDed with registered valid.
REQ-016 hazard_stall SHALL be combinational: ex_valid & ex_mem_read & ex_rd!=0 & id_valid & (ex_rd==id_rs | ex_rd==id_rt).
REQ-017 Forward select per operand: FWD_MEM if mem_reg_write & mem_rd!=0 & mem_rd==src; else FWD_WB if wb_reg_write & wb_rd!=0 & wb_rd==src; else FWD_NONE.
REQ-018 MEM SHALL take priority over WB when both match the same source.
REQ-019 ex_op_a/ex_rt_fwd SHALL be combinational from registered rs/rt value and forward select; register 0 never forwarded.
REQ-020 Forwarding SHALL be re-evaluated every cycle including while held by stall.
REQ-021 bubble_cnt SHALL increment by 1 on each edge a bubble is loaded by hazard_stall or flush (not rst), saturating at 16'hFFFF.
REQ-022 flush and stall asserted together SHALL produce a bubble; stall is ignored.

Reset
REQ-023 rst SHALL clear valid, all control bits, all data/index fields to 0 and bubble_cnt to 0 on the next edge.
REQ-024 rst mid-stall or mid-hazard SHALL override; hazard_stall SHALL read 0 the cycle after reset.
REQ-025 Outputs after reset: ex_valid 0, ex_op_a 0 unless forwarded, ex_rt_fwd 0 unless forwarded, ex_imm 0, ex_rd 0, controls 0, hazard_stall 0, bubble_cnt 0.

Structure
REQ-026 Package mips_pipe_pkg SHALL hold DATA_W, REG_W defaults and the fwd-select enum {FWD_NONE, FWD_MEM, FWD_WB}.
REQ-027 Sub-module fwd_sel SHALL implement REQ-017/018 for one source index, instantiated twice (rs, rt).

Verification
REQ-028 Load id_rs=3 val 0x0010, mem_rd=3 mem_reg_write=1 mem_result=0x1234 -> ex_op_a=0x1234 next cycle.
REQ-029 mem_rd=wb_rd=4 both writing, mem_result=0xAAAA wb_result=0x5555, ex rt=4 -> ex_rt_fwd=0xAAAA; with mem_reg_write=0 -> 0x5555.
REQ-030 EX holds lw to rd=7, ID uses rs=7 -> hazard_stall=1, next edge ex_valid=0, bubble_cnt=1; rd=0 variant -> hazard_stall=0.
REQ-031 stall=1 for 3 cycles with changing id_* -> all ex_* fields constant; flush+stall same edge -> ex_valid=0.
REQ-032 rst asserted during stall with ex_valid=1 -> ex_valid=0, ex_imm=0, bubble_cnt=0 after edge.
REQ-033 Preload bubble_cnt to 0xFFFE, two flushes -> holds 0xFFFF.
